// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: operand, DSP and result signals of the MAC sequencer
interface mac_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic        dsp_ce;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        m_valid;
  logic        m_ready;
  logic [47:0] m_data;
  modport master (
    input  s_valid, s_a, s_b, dsp_p, m_ready,
    output s_ready, dsp_a, dsp_b, dsp_ce, dsp_opmode, m_valid, m_data
  );
  modport slave (
    output s_valid, s_a, s_b, dsp_p, m_ready,
    input  s_ready, dsp_a, dsp_b, dsp_ce, dsp_opmode, m_valid, m_data
  );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: feeds operand pairs and OPMODEs to a DSP slice and returns each dot product
module mac_sequencer #(
  parameter int NTAPS    = 4,
  parameter int OPM_SKEW = 1,
  parameter int RES_LAT  = 2
) (
  input logic            clk,
  input logic            rst_n,
  mac_sequencer_if.master bus
);
  localparam int TW = $clog2(NTAPS + 1);
  localparam logic [7:0] OP_FIRST = 8'h01;
  localparam logic [7:0] OP_ACC   = 8'h09;
  localparam logic [7:0] OP_HOLD  = 8'h08;
  localparam logic [2:0] DRAIN_LAST = 3'(OPM_SKEW + RES_LAT);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
  state_t        r_state, w_next;
  logic [TW-1:0] r_tap, w_tap;
  logic [2:0]    r_cnt;
  logic          w_acc;
  logic [7:0]    w_op;
  logic [7:0]    r_pipe [OPM_SKEW+1];
  logic [17:0]   r_dsp_a, r_dsp_b;
  logic          r_dsp_ce;
  logic          r_m_valid;
  logic [47:0]   r_m_data;
  logic          w_capture;
  assign bus.s_ready    = rst_n & (r_state == IDLE | r_state == ACCUM);
  assign w_acc          = bus.s_valid & bus.s_ready;
  assign w_op           = !w_acc ? OP_HOLD : r_state == IDLE ? OP_FIRST : OP_ACC;
  assign w_capture      = r_state == DRAIN && r_cnt == DRAIN_LAST;
  assign bus.dsp_a      = r_dsp_a;
  assign bus.dsp_b      = r_dsp_b;
  assign bus.dsp_ce     = r_dsp_ce;
  assign bus.dsp_opmode = r_pipe[OPM_SKEW];
  assign bus.m_valid    = r_m_valid;
  assign bus.m_data     = r_m_data;
  // next state and tap count
  always_comb begin
    w_next = r_state;
    w_tap  = r_tap;
    case (r_state)
      IDLE:  if (w_acc) begin
        w_tap  = TW'(1);
        w_next = NTAPS == 1 ? DRAIN : ACCUM;
      end
      ACCUM: if (w_acc) begin
        w_tap  = r_tap + 1'b1;
        w_next = w_tap == TW'(NTAPS) ? DRAIN : ACCUM;
      end
      DRAIN: w_next = w_capture ? HOLD : DRAIN;
      HOLD:  if (bus.m_ready) begin
        w_next = IDLE;
        w_tap  = '0;
      end
    endcase
  end
  // state, tap count and drain timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tap   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_tap   <= w_tap;
      r_cnt   <= r_state == DRAIN ? r_cnt + 3'd1 : 3'd0;
    end
  end
  // operand registers, loaded only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dsp_a  <= '0;
      r_dsp_b  <= '0;
      r_dsp_ce <= 1'b0;
    end else begin
      r_dsp_ce <= w_acc;
      if (w_acc) begin
        r_dsp_a <= bus.s_a;
        r_dsp_b <= bus.s_b;
      end
    end
  end
  // opcode delay line; last stage is the registered OPMODE output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= OPM_SKEW; i++) r_pipe[i] <= OP_HOLD;
    end else begin
      r_pipe[0] <= w_op;
      for (int i = 1; i <= OPM_SKEW; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  // capture P once the final accumulate has settled, hold it until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_capture) begin
      r_m_valid <= 1'b1;
      r_m_data  <= bus.dsp_p;
    end else if (r_state == HOLD && bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed checks of the sequencer against a registered DSP model
module tb_mac_sequencer;
  localparam int LAT = 1 + 1 + 2;
  logic clk = 0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   rec = 0;
  logic [7:0] opq [$];
  mac_sequencer_if ifc();
  mac_sequencer_if ifc1();
  mac_sequencer #(.NTAPS(4), .OPM_SKEW(1), .RES_LAT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));
  mac_sequencer #(.NTAPS(1), .OPM_SKEW(1), .RES_LAT(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rec) opq.push_back(ifc.dsp_opmode);
  logic [17:0] a0, b0, a1, b1;
  logic [47:0] m0, m1;
  logic [7:0]  o0, o1;
  // DSP models: A/B reg with CE, M reg, OPMODE reg, P reg
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0 <= 0; b0 <= 0; m0 <= 0; o0 <= 8'h08; ifc.dsp_p <= 0;
    end else begin
      if (ifc.dsp_ce) begin a0 <= ifc.dsp_a; b0 <= ifc.dsp_b; end
      m0 <= 48'(a0) * 48'(b0);
      o0 <= ifc.dsp_opmode;
      ifc.dsp_p <= (o0[1:0] == 2'b01 ? m0 : 48'd0) + (o0[3] ? ifc.dsp_p : 48'd0);
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= 0; b1 <= 0; m1 <= 0; o1 <= 8'h08; ifc1.dsp_p <= 0;
    end else begin
      if (ifc1.dsp_ce) begin a1 <= ifc1.dsp_a; b1 <= ifc1.dsp_b; end
      m1 <= 48'(a1) * 48'(b1);
      o1 <= ifc1.dsp_opmode;
      ifc1.dsp_p <= (o1[1:0] == 2'b01 ? m1 : 48'd0) + (o1[3] ? ifc1.dsp_p : 48'd0);
    end
  end
  task automatic send(input logic [17:0] a, input logic [17:0] b);
    int n = 0;
    ifc.s_a = a; ifc.s_b = b; ifc.s_valid = 1;
    while (!ifc.s_ready && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (ifc.s_ready !== 1'b1) begin errors++; $display("FAIL send_ready got %b want 1", ifc.s_ready); end
    @(posedge clk); #1;
    last_acc = cyc;
    ifc.s_valid = 0;
  endtask
  task automatic get_result(input logic [47:0] exp, input string nm);
    int n = 0;
    while (!ifc.m_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (ifc.m_valid !== 1'b1) begin errors++; $display("FAIL %s_timeout m_valid got %b want 1", nm, ifc.m_valid); end
    checks++;
    if (cyc - last_acc !== LAT) begin errors++; $display("FAIL %s_latency got %0d want %0d", nm, cyc - last_acc, LAT); end
    checks++;
    if (ifc.m_data !== exp) begin errors++; $display("FAIL %s_data got %0h want %0h", nm, ifc.m_data, exp); end
    ifc.m_ready = 1; @(posedge clk); #1; ifc.m_ready = 0;
    checks++;
    if (ifc.m_valid !== 1'b0) begin errors++; $display("FAIL %s_clear m_valid got %b want 0", nm, ifc.m_valid); end
  endtask
  task automatic test_reset;
    rst_n = 1; #1 rst_n = 0; #1;
    checks++;
    if (ifc.s_ready !== 0 || ifc.dsp_ce !== 0 || ifc.dsp_a !== 0 || ifc.dsp_b !== 0 ||
        ifc.dsp_opmode !== 8'h08 || ifc.m_valid !== 0 || ifc.m_data !== 0)
    begin errors++; $display("FAIL reset_state got rdy=%b ce=%b a=%h b=%h op=%h v=%b d=%h", ifc.s_ready, ifc.dsp_ce, ifc.dsp_a, ifc.dsp_b, ifc.dsp_opmode, ifc.m_valid, ifc.m_data); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1; #1;
    checks++;
    if (ifc.s_ready !== 1'b1) begin errors++; $display("FAIL reset_release s_ready got %b want 1", ifc.s_ready); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] exp [4] = '{8'h01, 8'h09, 8'h09, 8'h09};
    int s = -1;
    opq.delete(); rec = 1;
    send(1, 5);
    checks++;
    if (ifc.dsp_ce !== 1'b1 || ifc.dsp_a !== 18'd1 || ifc.dsp_b !== 18'd5)
    begin errors++; $display("FAIL b2b_operand got ce=%b a=%0d b=%0d want 1 1 5", ifc.dsp_ce, ifc.dsp_a, ifc.dsp_b); end
    send(2, 6); send(3, 7); send(4, 8);
    get_result(48'd70, "b2b");
    rec = 0;
    foreach (opq[i]) if (s < 0 && opq[i] == 8'h01) s = i;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s < 0 || s + i >= opq.size() || opq[s+i] !== (i < 4 ? exp[i] : 8'h08))
      begin errors++; $display("FAIL b2b_opmode[%0d] got %h want %h", i, (s < 0 || s + i >= opq.size()) ? 8'hxx : opq[s+i], i < 4 ? exp[i] : 8'h08); end
    end
  endtask
  task automatic test_gapped;
    logic [7:0] exp [7] = '{8'h01, 8'h09, 8'h08, 8'h08, 8'h08, 8'h09, 8'h09};
    int s = -1;
    opq.delete(); rec = 1;
    send(1, 5); send(2, 6);
    @(posedge clk); #1;
    checks++;
    if (ifc.dsp_ce !== 1'b0 || ifc.dsp_a !== 18'd2 || ifc.s_ready !== 1'b1)
    begin errors++; $display("FAIL gap_hold got ce=%b a=%0d rdy=%b want 0 2 1", ifc.dsp_ce, ifc.dsp_a, ifc.s_ready); end
    repeat (2) @(posedge clk); #1;
    send(3, 7); send(4, 8);
    get_result(48'd70, "gap");
    rec = 0;
    foreach (opq[i]) if (s < 0 && opq[i] == 8'h01) s = i;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (s < 0 || s + i >= opq.size() || opq[s+i] !== exp[i])
      begin errors++; $display("FAIL gap_opmode[%0d] got %h want %h", i, (s < 0 || s + i >= opq.size()) ? 8'hxx : opq[s+i], exp[i]); end
    end
  endtask
  task automatic test_backpressure;
    int n = 0;
    send(1, 5); send(2, 6); send(3, 7); send(4, 8);
    while (!ifc.m_valid && n < 50) begin @(posedge clk); #1; n++; end
    ifc.s_valid = 1; ifc.s_a = 18'h155; ifc.s_b = 18'h2AA;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifc.m_valid !== 1'b1 || ifc.m_data !== 48'd70 || ifc.s_ready !== 1'b0 || ifc.dsp_ce !== 1'b0)
      begin errors++; $display("FAIL bp_hold[%0d] got v=%b d=%0d rdy=%b ce=%b want 1 70 0 0", i, ifc.m_valid, ifc.m_data, ifc.s_ready, ifc.dsp_ce); end
      @(posedge clk); #1;
    end
    ifc.s_valid = 0;
    ifc.m_ready = 1; @(posedge clk); #1; ifc.m_ready = 0;
    checks++;
    if (ifc.m_valid !== 1'b0 || ifc.s_ready !== 1'b1)
    begin errors++; $display("FAIL bp_release got v=%b rdy=%b want 0 1", ifc.m_valid, ifc.s_ready); end
    for (int i = 0; i < 4; i++) send(2, 3);
    get_result(48'd24, "bp_next");
  endtask
  task automatic test_reset_midframe;
    send(1, 5); send(2, 6);
    #2 rst_n = 0; #1;
    checks++;
    if (ifc.s_ready !== 0 || ifc.dsp_ce !== 0 || ifc.dsp_a !== 0 || ifc.dsp_b !== 0 ||
        ifc.dsp_opmode !== 8'h08 || ifc.m_valid !== 0 || ifc.m_data !== 0)
    begin errors++; $display("FAIL mid_reset got rdy=%b ce=%b a=%h b=%h op=%h v=%b d=%h", ifc.s_ready, ifc.dsp_ce, ifc.dsp_a, ifc.dsp_b, ifc.dsp_opmode, ifc.m_valid, ifc.m_data); end
    @(posedge clk); #3 rst_n = 1; #1;
    checks++;
    if (ifc.s_ready !== 1'b1) begin errors++; $display("FAIL mid_release s_ready got %b want 1", ifc.s_ready); end
    opq.delete(); rec = 1;
    for (int i = 0; i < 4; i++) send(1, 1);
    get_result(48'd4, "post_reset");
    rec = 0;
    checks++;
    if (opq.size() < 3 || opq[2] !== 8'h01)
    begin errors++; $display("FAIL post_reset_first got %h want 01", opq.size() < 3 ? 8'hxx : opq[2]); end
  endtask
  task automatic test_ntaps1;
    int n = 0;
    int acc;
    ifc1.s_a = 18'h3FFFF; ifc1.s_b = 18'h3FFFF; ifc1.s_valid = 1;
    checks++;
    if (ifc1.s_ready !== 1'b1) begin errors++; $display("FAIL n1_ready got %b want 1", ifc1.s_ready); end
    @(posedge clk); #1;
    acc = cyc; ifc1.s_valid = 0;
    checks++;
    if (ifc1.s_ready !== 1'b0) begin errors++; $display("FAIL n1_drain s_ready got %b want 0", ifc1.s_ready); end
    while (!ifc1.m_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (cyc - acc !== LAT) begin errors++; $display("FAIL n1_latency got %0d want %0d", cyc - acc, LAT); end
    checks++;
    if (ifc1.m_data !== 48'h000F_FFF8_0001) begin errors++; $display("FAIL n1_data got %h want 000ffff80001", ifc1.m_data); end
    ifc1.m_ready = 1; @(posedge clk); #1; ifc1.m_ready = 0;
    checks++;
    if (ifc1.m_valid !== 1'b0 || ifc1.s_ready !== 1'b1)
    begin errors++; $display("FAIL n1_clear got v=%b rdy=%b want 0 1", ifc1.m_valid, ifc1.s_ready); end
  endtask
  initial begin
    ifc.s_valid = 0; ifc.s_a = 0; ifc.s_b = 0; ifc.m_ready = 0;
    ifc1.s_valid = 0; ifc1.s_a = 0; ifc1.s_b = 0; ifc1.m_ready = 0;
    test_reset;
    test_back_to_back;
    test_gapped;
    test_backpressure;
    test_reset_midframe;
    test_ntaps1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
